div_ctrl: RTL and testbench
===========================

Name: div_ctrl

Overview:
- Multi-cycle radix-2 restoring divider with its sequencing FSM.
- Instantiated beside the ALU in the EX stage. It produces the 64-bit div_res the ALU writes to HI/LO for DIV/DIVU.
- Holds the pipeline through stall until the result is ready.
- Supports signed and unsigned operands, divide-by-zero and annulment (flush/exception) mid-operation.

Parameters:
- DW, 32, operand width; result is 2*DW. The iteration counter is clog2(DW)+1 bits.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-low reset.
- signed_div  input  1  1 = DIV (signed), 0 = DIVU; sampled with start.
- opdata1  input  DW  dividend (rs); sampled with start.
- opdata2  input  DW  divisor (rt); sampled with start.
- start  input  1  request; held high by EX until ready is seen.
- annul  input  1  abort the current operation (flush/exception).
- result  output  2*DW  {remainder, quotient} = {HI, LO}.
- ready  output  1  result valid.
- stall  output  1  pipeline hold request.

Behaviour:
- Reset (rst=0, async): state=IDLE, result=0, ready=0, counter=0, internal registers=0. Reset wins over all other inputs at any time, including mid-divide.
- stall = start & ~ready & ~annul (combinational).
- State IDLE:
  - On an edge with start=1, annul=0 and opdata2==0: go to DIVZERO.
  - On an edge with start=1, annul=0 and opdata2!=0:
    - Latch |opdata1| and |opdata2| (absolute values only when signed_div=1; raw values otherwise).
    - Latch the sign flags qneg = s1^s2 and rneg = s1, where s1/s2 are the operand MSBs and signed_div=1; both flags are 0 when unsigned.
    - Clear the partial remainder and set counter=0, then go to ON.
- State DIVZERO: on the next edge, result = {opdata1 latched, {DW{1'b1}}} regardless of sign, then go to END.
- State ON, one restoring step per edge:
  - Shift {rem, quot} left 1.
  - Trial-subtract the divisor from rem, a DW+1-bit subtract.
  - If non-negative, keep the difference and set the quot LSB to 1; otherwise restore and set the LSB to 0.
  - counter += 1.
  - When the step at counter == DW-1 completes, go to END. Result is registered in the same edge as:
    - quotient = qneg ? -quot : quot
    - remainder = rneg ? -rem : rem
- State END: ready=1 and result held. Stay in END while start=1. When start=0, go to IDLE with ready=0 and result held until the next completion.
- Annul: in ON, DIVZERO or END, annul=1 at an edge forces IDLE, ready=0 and result unchanged. In IDLE, annul blocks acceptance of start.
- Latency: the edge sampling start is edge 0. ready is high after edge DW+1 (33 for DW=32). For divide-by-zero, ready is high after edge 2.
- Operands are captured only in IDLE. Changes to opdata1, opdata2 or signed_div during ON are ignored.
- Overflow case, signed 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0. No trap.
- start held high after ready must not restart the divide. A new divide requires start to go low for at least one cycle, which passes through IDLE.

Test Plan:
- Unsigned: signed_div=0, 100 / 7, start held -> stall=1 for edges 0..32, ready after edge 33, result={0x00000002, 0x0000000E}. start dropped -> IDLE, ready=0.
- Signed negatives:
  - -7 / 2 -> result={0xFFFFFFFF, 0xFFFFFFFD}.
  - 7 / -2 -> {0x00000001, 0xFFFFFFFD}.
- Boundary operands:
  - Signed 0x80000000 / 0xFFFFFFFF -> {0x00000000, 0x80000000}.
  - Unsigned 0xFFFFFFFF / 1 -> {0, 0xFFFFFFFF}.
- Divide by zero: opdata1=0x12345678, opdata2=0 -> ready after edge 2, result={0x12345678, 0xFFFFFFFF}.
- Annul at edge 10 of a divide -> IDLE next edge, ready never asserts, prior result unchanged. A following 9/3 completes to {0, 3} with normal latency.
- Reset mid-op: rst low asynchronously at edge 15 -> result=0, ready=0, stall follows start. After release, a new 50/5 yields {0, 0x0000000A}.

Source files
------------

// File: rtl/div_ctrl.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU in the EX stage.
// Produces {remainder, quotient} and holds the pipeline through stall until ready.
module div_ctrl #(
  parameter int unsigned DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            signed_div,
  input  logic [DW-1:0]   opdata1,
  input  logic [DW-1:0]   opdata2,
  input  logic            start,
  input  logic            annul,
  output logic [2*DW-1:0] result,
  output logic            ready,
  output logic            stall
);

  localparam int unsigned CW = $clog2(DW) + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ON      = 2'd1,
    S_DIVZERO = 2'd2,
    S_END     = 2'd3
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_rem;
  logic [DW-1:0] r_quot;
  logic [DW-1:0] r_dvsr;
  logic          r_qneg;
  logic          r_rneg;

  logic          w_s1;
  logic          w_s2;
  logic [DW-1:0] w_abs1;
  logic [DW-1:0] w_abs2;
  logic [DW:0]   w_rem_sh;
  logic [DW:0]   w_diff;
  logic          w_ge;
  logic [DW-1:0] w_rem_nx;
  logic [DW-1:0] w_quot_nx;
  logic [DW-1:0] w_rem_fin;
  logic [DW-1:0] w_quot_fin;

  // Operand magnitudes and signs; sign handling only for DIV.
  assign w_s1   = signed_div & opdata1[DW-1];
  assign w_s2   = signed_div & opdata2[DW-1];
  assign w_abs1 = w_s1 ? (~opdata1 + DW'(1)) : opdata1;
  assign w_abs2 = w_s2 ? (~opdata2 + DW'(1)) : opdata2;

  // One restoring step: shift, trial-subtract, keep or restore.
  assign w_rem_sh  = {r_rem, r_quot[DW-1]};
  assign w_diff    = w_rem_sh - {1'b0, r_dvsr};
  assign w_ge      = ~w_diff[DW];
  assign w_rem_nx  = w_ge ? w_diff[DW-1:0] : w_rem_sh[DW-1:0];
  assign w_quot_nx = {r_quot[DW-2:0], w_ge};

  assign w_quot_fin = r_qneg ? (~w_quot_nx + DW'(1)) : w_quot_nx;
  assign w_rem_fin  = r_rneg ? (~w_rem_nx + DW'(1)) : w_rem_nx;

  assign stall = start & ~ready & ~annul;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_quot  <= '0;
      r_dvsr  <= '0;
      r_qneg  <= 1'b0;
      r_rneg  <= 1'b0;
      result  <= '0;
      ready   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          ready <= 1'b0;
          if (start && !annul) begin
            if (opdata2 == '0) begin
              // Dividend parked in the quotient register for the div-by-zero result.
              r_quot  <= opdata1;
              r_state <= S_DIVZERO;
            end else begin
              r_quot  <= w_abs1;
              r_dvsr  <= w_abs2;
              r_qneg  <= w_s1 ^ w_s2;
              r_rneg  <= w_s1;
              r_rem   <= '0;
              r_cnt   <= '0;
              r_state <= S_ON;
            end
          end
        end
        S_DIVZERO: begin
          if (annul) begin
            ready   <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            result  <= {r_quot, {DW{1'b1}}};
            r_state <= S_END;
          end
        end
        S_ON: begin
          if (annul) begin
            ready   <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_rem  <= w_rem_nx;
            r_quot <= w_quot_nx;
            r_cnt  <= r_cnt + CW'(1);
            if (r_cnt == CW'(DW - 1)) begin
              result  <= {w_rem_fin, w_quot_fin};
              r_state <= S_END;
            end
          end
        end
        S_END: begin
          // Stay done while EX keeps start high; a new divide needs start low first.
          if (annul || !start) begin
            ready   <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            ready <= 1'b1;
          end
        end
        default: begin
          ready   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: directed vector table, multi-cycle corner
// sequences, and randomized operations checked against an arithmetic model.
module tb_div_ctrl;

  logic        clk;
  logic        rst;
  logic        signed_div;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic        start;
  logic        annul;
  logic [63:0] result;
  logic        ready;
  logic        stall;

  int errors = 0;
  int checks = 0;

  div_ctrl #(.DW(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .signed_div(signed_div),
    .opdata1   (opdata1),
    .opdata2   (opdata2),
    .start     (start),
    .annul     (annul),
    .result    (result),
    .ready     (ready),
    .stall     (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sd;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
    end
  endtask

  // Reference: quotient truncates toward zero, remainder takes dividend's sign.
  function automatic logic [63:0] model(input logic sd, input logic [31:0] a, input logic [31:0] b);
    longint la, lb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sd) begin
      la = longint'($signed(a));
      lb = longint'($signed(b));
    end else begin
      la = longint'({32'd0, a});
      lb = longint'({32'd0, b});
    end
    q = la / lb;
    r = la % lb;
    return {r[31:0], q[31:0]};
  endfunction

  // Raise start and wait for ready; edge 0 is the first edge with start high.
  task automatic do_div(input logic sd, input logic [31:0] a, input logic [31:0] b,
                        output logic [63:0] res, output int lat, output int stall_bad);
    @(negedge clk);
    signed_div = sd;
    opdata1    = a;
    opdata2    = b;
    start      = 1'b1;
    lat        = -1;
    stall_bad  = 0;
    for (int e = 0; e < 100; e++) begin
      @(posedge clk);
      #1;
      if (ready) begin
        lat = e;
        break;
      end
      if (stall !== 1'b1) stall_bad++;
    end
    res = result;
  endtask

  task automatic drop_start(input logic [63:0] held);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_low_after_drop", {63'd0, ready}, 64'd0);
    chk("result_held_idle", result, held);
  endtask

  vec_t        vecs[7];
  logic [63:0] res;
  logic [63:0] prior;
  int          lat;
  int          sbad;
  int          bad;

  initial begin
    vecs[0] = '{1'b0, 32'd100,        32'd7,          {32'h0000_0002, 32'h0000_000E}, 33};
    vecs[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33};
    vecs[2] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  {32'h0000_0001, 32'hFFFF_FFFD}, 33};
    vecs[3] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  {32'h0000_0000, 32'h8000_0000}, 33};
    vecs[4] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          {32'h0000_0000, 32'hFFFF_FFFF}, 33};
    vecs[5] = '{1'b0, 32'h1234_5678,  32'd0,          {32'h1234_5678, 32'hFFFF_FFFF}, 2};
    vecs[6] = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  {32'h0000_0000, 32'h0000_0001}, 33};

    rst = 1'b1; signed_div = 1'b0; opdata1 = '0; opdata2 = '0; start = 1'b0; annul = 1'b0;
    #3 rst = 1'b0;
    #2;
    chk("reset_result", result, 64'd0);
    chk("reset_ready", {63'd0, ready}, 64'd0);
    start = 1'b1;
    #1;
    chk("reset_stall_follows_start", {63'd0, stall}, 64'd1);
    start = 1'b0;
    #1;
    chk("reset_stall_low", {63'd0, stall}, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Directed vectors, each also held after ready to confirm no restart.
    for (int i = 0; i < 7; i++) begin
      do_div(vecs[i].sd, vecs[i].a, vecs[i].b, res, lat, sbad);
      chk($sformatf("vec%0d_result", i), res, vecs[i].exp);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
      chk($sformatf("vec%0d_stall", i), 64'(sbad), 64'd0);
      bad = 0;
      for (int k = 0; k < 4; k++) begin
        @(posedge clk);
        #1;
        if (ready !== 1'b1 || result !== vecs[i].exp || stall !== 1'b0) bad++;
      end
      chk($sformatf("vec%0d_hold_no_restart", i), 64'(bad), 64'd0);
      drop_start(vecs[i].exp);
    end
    prior = vecs[6].exp;

    // Operand changes while dividing must be ignored.
    @(negedge clk);
    signed_div = 1'b0; opdata1 = 32'd200; opdata2 = 32'd9; start = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    signed_div = 1'b1; opdata1 = 32'hFFFF_FF00; opdata2 = 32'd1;
    lat = -1;
    for (int e = 3; e < 100; e++) begin
      @(posedge clk);
      #1;
      if (ready) begin lat = e; break; end
    end
    chk("opchange_result", result, {32'd2, 32'd22});
    chk("opchange_latency", 64'(lat), 64'd33);
    prior = {32'd2, 32'd22};
    drop_start(prior);

    // Annul at edge 10: no completion, prior result kept.
    @(negedge clk);
    signed_div = 1'b0; opdata1 = 32'd1000; opdata2 = 32'd3; start = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    annul = 1'b1;
    #1;
    chk("annul_stall_low", {63'd0, stall}, 64'd0);
    @(posedge clk);
    #1;
    chk("annul_ready", {63'd0, ready}, 64'd0);
    chk("annul_result_kept", result, prior);
    @(negedge clk);
    annul = 1'b0; start = 1'b0;
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (ready !== 1'b0 || result !== prior) bad++;
    end
    chk("annul_never_ready", 64'(bad), 64'd0);
    do_div(1'b0, 32'd9, 32'd3, res, lat, sbad);
    chk("after_annul_result", res, {32'd0, 32'd3});
    chk("after_annul_latency", 64'(lat), 64'd33);
    prior = res;

    // Annul in END drops ready and keeps the result.
    @(negedge clk);
    annul = 1'b1;
    @(posedge clk);
    #1;
    chk("annul_end_ready", {63'd0, ready}, 64'd0);
    chk("annul_end_result", result, prior);
    @(negedge clk);
    annul = 1'b0; start = 1'b0;
    @(posedge clk);

    // Annul in IDLE blocks acceptance of a divide by zero.
    @(negedge clk);
    opdata1 = 32'hDEAD_BEEF; opdata2 = 32'd0; start = 1'b1; annul = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    start = 1'b0; annul = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("idle_annul_blocks", result, prior);

    // Asynchronous reset in the middle of a divide.
    @(negedge clk);
    signed_div = 1'b0; opdata1 = 32'd77777; opdata2 = 32'd13; start = 1'b1;
    repeat (16) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midreset_result", result, 64'd0);
    chk("midreset_ready", {63'd0, ready}, 64'd0);
    chk("midreset_stall", {63'd0, stall}, 64'd1);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    do_div(1'b0, 32'd50, 32'd5, res, lat, sbad);
    chk("postreset_result", res, {32'd0, 32'h0000_000A});
    chk("postreset_latency", 64'(lat), 64'd33);
    drop_start(res);

    // Randomized operations against the arithmetic model.
    for (int n = 0; n < 40; n++) begin
      logic        sd;
      logic [31:0] a, b;
      sd = 1'($urandom_range(0, 1));
      a  = $urandom;
      case ($urandom_range(0, 4))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      if (n % 5 == 0) a = 32'($urandom_range(0, 100));
      do_div(sd, a, b, res, lat, sbad);
      chk($sformatf("rand%0d_result sd=%0d a=%h b=%h", n, sd, a, b), res, model(sd, a, b));
      chk($sformatf("rand%0d_latency", n), 64'(lat), (b == 32'd0) ? 64'd2 : 64'd33);
      drop_start(res);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
